// File: rtl/rom_axi_pkg.sv
// Shared types and the burst address helper for the ROM AXI read slave.
package rom_axi_pkg;

  typedef enum logic [1:0] {
    B_FIXED = 2'b00,
    B_INCR  = 2'b01,
    B_WRAP  = 2'b10,
    B_RSVD  = 2'b11
  } burst_e;

  typedef enum logic [1:0] {
    R_OKAY   = 2'b00,
    R_EXOKAY = 2'b01,
    R_SLVERR = 2'b10,
    R_DECERR = 2'b11
  } resp_e;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_e;

  localparam int unsigned NA_W = 32;

  // Word-granular next beat address; callers truncate to the ROM width.
  function automatic logic [NA_W-1:0] next_addr(
    input logic [NA_W-1:0] addr,
    input logic [NA_W-1:0] len,
    input burst_e          burst
  );
    logic [NA_W-1:0] n;
    n = addr;
    unique case (burst)
      B_INCR:  n = addr + 32'd1;
      B_WRAP:  n = (addr & ~len) | ((addr + 32'd1) & len);
      default: n = addr;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/rom_axi_rd_slave_if.sv
// AXI read-address / read-data channel bundle for the ROM read slave.
interface rom_axi_rd_slave_if #(
  parameter int ID_W   = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
);
  logic [ID_W-1:0]   ARID_S;
  logic [ADDR_W-1:0] ARADDR_S;
  logic [LEN_W-1:0]  ARLEN_S;
  logic [2:0]        ARSIZE_S;
  logic [1:0]        ARBURST_S;
  logic              ARVALID_S;
  logic              ARREADY_S;
  logic [ID_W-1:0]   RID_S;
  logic [DATA_W-1:0] RDATA_S;
  logic [1:0]        RRESP_S;
  logic              RLAST_S;
  logic              RVALID_S;
  logic              RREADY_S;

  modport slave (
    input  ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S,
    input  ARBURST_S, ARVALID_S, RREADY_S,
    output ARREADY_S, RID_S, RDATA_S, RRESP_S,
    output RLAST_S, RVALID_S
  );

  modport master (
    output ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S,
    output ARBURST_S, ARVALID_S, RREADY_S,
    input  ARREADY_S, RID_S, RDATA_S, RRESP_S,
    input  RLAST_S, RVALID_S
  );
endinterface

// File: rtl/rom_rd_buf.sv
// Two-entry fall-through FIFO for read beats; an empty buffer passes the
// incoming beat straight to the output so ROM data reaches R in one cycle.
module rom_rd_buf #(
  parameter int W = 35
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  output logic [W-1:0] out_data_o,
  input  logic         out_ready_i,
  output logic [1:0]   count_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_q, wr_d;
  logic         rd_q, rd_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         empty;
  logic         bypass;
  logic         push;
  logic         pop;

  always_comb begin
    empty  = (cnt_q == 2'd0);
    bypass = in_valid_i && empty && out_ready_i;
    push   = in_valid_i && !bypass;
    pop    = out_ready_i && !empty;
    wr_d   = push ? ~wr_q : wr_q;
    rd_d   = pop ? ~rd_q : rd_q;
    cnt_d  = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  assign out_valid_o = !empty || in_valid_i;
  assign out_data_o  = !empty    ? mem_q[rd_q] :
                       in_valid_i ? in_data_i  : '0;
  assign count_o     = cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (push) mem_q[wr_q] <= in_data_i;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rom_axi_rd_slave.sv
// AXI read-only slave in front of a synchronous ROM (FIXED/INCR/WRAP).
// Define ROM_PARITY_EN to add the DP byte-parity input and its check.
module rom_axi_rd_slave
  import rom_axi_pkg::*;
#(
  parameter  int ID_W   = 8,
  parameter  int ADDR_W = 32,
  parameter  int DATA_W = 32,
  parameter  int LEN_W  = 4,
  parameter  int DEPTH  = 4096,
  localparam int LSB    = $clog2(DATA_W / 8),
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              ACLK,
  input  logic              ARESET,
  rom_axi_rd_slave_if.slave s,
  output logic              OE,
  output logic              CS,
  output logic [AW-1:0]     A,
  input  logic [DATA_W-1:0] DO
`ifdef ROM_PARITY_EN
  ,
  input  logic [DATA_W/8-1:0] DP
`endif
);

  localparam int BW = DATA_W + 3;

  state_e            state_q, state_d;
  logic              arready_q, arready_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  burst_e            burst_q, burst_d;
  resp_e             err_q, err_d;
  logic [LEN_W-1:0]  beat_q, beat_d;
  logic              done_q, done_d;
  logic              infl_q, infl_d;
  logic              infl_last_q, infl_last_d;
  resp_e             infl_resp_q, infl_resp_d;

  logic              ar_hs;
  logic              last_hs;
  logic              issue;
  logic [1:0]        buf_cnt;
  logic              slv;
  logic              dec;
  logic              wrap_ok;
  resp_e             ar_resp;
  resp_e             cap_resp;
  logic [DATA_W-1:0] cap_data;
  logic [BW-1:0]     buf_in;
  logic [BW-1:0]     buf_out;
  logic              par_bad;

  // Burst-wide error class decided once from the AR fields.
  always_comb begin
    wrap_ok = (s.ARLEN_S != '0) &&
              ((s.ARLEN_S & (s.ARLEN_S + LEN_W'(1))) == '0);
    slv = (s.ARSIZE_S > 3'(LSB)) ||
          (s.ARBURST_S == 2'b11) ||
          ((s.ARBURST_S == 2'b10) && !wrap_ok);
    dec = (s.ARADDR_S >> (LSB + AW)) != '0;
    ar_resp = R_OKAY;
    unique case (1'b1)
      slv:         ar_resp = R_SLVERR;
      !slv && dec: ar_resp = R_DECERR;
      default:     ar_resp = R_OKAY;
    endcase
  end

  always_comb begin
    ar_hs   = s.ARVALID_S && arready_q;
    last_hs = s.RVALID_S && s.RREADY_S && s.RLAST_S;
    issue   = (state_q == S_BURST) && !done_q &&
              (({1'b0, buf_cnt} + {2'b00, infl_q}) < 3'd2);
  end

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    addr_d      = addr_q;
    len_d       = len_q;
    burst_d     = burst_q;
    err_d       = err_q;
    beat_d      = beat_q;
    done_d      = done_q;
    unique case (state_q)
      S_IDLE: begin
        if (ar_hs) begin
          state_d = S_BURST;
          id_d    = s.ARID_S;
          addr_d  = s.ARADDR_S[LSB +: AW];
          len_d   = s.ARLEN_S;
          burst_d = burst_e'(s.ARBURST_S);
          err_d   = ar_resp;
          beat_d  = '0;
          done_d  = 1'b0;
        end
      end
      S_BURST: begin
        if (issue) begin
          addr_d = AW'(next_addr(NA_W'(addr_q),
                                 NA_W'(len_q), burst_q));
          beat_d = beat_q + LEN_W'(1);
          done_d = (beat_q == len_q);
        end
        if (last_hs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    arready_d   = (state_d == S_IDLE);
    infl_d      = issue;
    infl_last_d = (beat_q == len_q);
    infl_resp_d = err_q;
  end

  assign CS = issue && (err_q == R_OKAY);
  assign OE = CS;
  assign A  = addr_q;

  always_comb begin
    par_bad = 1'b0;
`ifdef ROM_PARITY_EN
    for (int i = 0; i < DATA_W / 8; i++) begin
      if (DP[i] != ^DO[8*i +: 8]) par_bad = 1'b1;
    end
`endif
    cap_resp = infl_resp_q;
    if ((infl_resp_q == R_OKAY) && par_bad) cap_resp = R_SLVERR;
    cap_data = (infl_resp_q == R_OKAY) ? DO : '0;
    buf_in   = {cap_data, cap_resp, infl_last_q};
  end

  rom_rd_buf #(
    .W(BW)
  ) u_buf (
    .clk_i      (ACLK),
    .rst_i      (ARESET),
    .in_valid_i (infl_q),
    .in_data_i  (buf_in),
    .out_valid_o(s.RVALID_S),
    .out_data_o (buf_out),
    .out_ready_i(s.RREADY_S),
    .count_o    (buf_cnt)
  );

  assign s.RDATA_S   = buf_out[BW-1:3];
  assign s.RRESP_S   = buf_out[2:1];
  assign s.RLAST_S   = buf_out[0];
  assign s.RID_S     = id_q;
  assign s.ARREADY_S = arready_q;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= S_IDLE;
      arready_q   <= 1'b0;
      id_q        <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      burst_q     <= B_FIXED;
      err_q       <= R_OKAY;
      beat_q      <= '0;
      done_q      <= 1'b0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      infl_resp_q <= R_OKAY;
    end else begin
      state_q     <= state_d;
      arready_q   <= arready_d;
      id_q        <= id_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      burst_q     <= burst_d;
      err_q       <= err_d;
      beat_q      <= beat_d;
      done_q      <= done_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
      infl_resp_q <= infl_resp_d;
    end
  end

endmodule

// File: tb/tb_rom_axi_rd_slave.sv
// Directed bench for rom_axi_rd_slave with a behavioural synchronous ROM.
// Define ROM_PARITY_EN to also exercise the DP parity check.
module tb_rom_axi_rd_slave;
  localparam int ID_W = 8;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LEN_W = 4;
  localparam int DEPTH = 4096;
  localparam int AW = 12;

  logic ACLK = 1'b0;
  logic ARESET;
  logic OE, CS;
  logic [AW-1:0] A;
  logic [DATA_W-1:0] DO = '0;
`ifdef ROM_PARITY_EN
  logic [3:0] DP = '0;
  int acc_n = 0;
  int flip_at = -1;
`endif

  int total = 0;
  int bad = 0;

  logic [31:0] bd [16];
  logic [1:0]  br [16];
  logic        bl [16];
  logic [7:0]  bid [16];
  int got, first_c, last_c, cs_n, unstable;

  rom_axi_rd_slave_if #(.ID_W(ID_W), .ADDR_W(ADDR_W),
    .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

  rom_axi_rd_slave #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .LEN_W(LEN_W), .DEPTH(DEPTH)) dut (
    .ACLK  (ACLK),
    .ARESET(ARESET),
    .s     (bus),
    .OE    (OE),
    .CS    (CS),
    .A     (A),
    .DO    (DO)
`ifdef ROM_PARITY_EN
    ,
    .DP    (DP)
`endif
  );

  always #5 ACLK = ~ACLK;

  function automatic logic [31:0] rom_word(input int i);
    return 32'hA500_0000 ^ (32'(i) << 16) ^ 32'(i);
  endfunction

  function automatic logic [3:0] par4(input logic [31:0] w);
    logic [3:0] p;
    for (int i = 0; i < 4; i++) p[i] = ^w[8*i +: 8];
    return p;
  endfunction

  always @(posedge ACLK) begin
    if (CS && OE) begin
      DO <= rom_word(int'(A));
`ifdef ROM_PARITY_EN
      DP <= par4(rom_word(int'(A))) ^ ((acc_n == flip_at) ? 4'b0001 : 4'b0000);
      acc_n <= acc_n + 1;
`endif
    end
  end

  task automatic send_ar(input logic [7:0] id, input logic [31:0] addr,
      input logic [3:0] len, input logic [2:0] size, input logic [1:0] burst,
      output bit ok);
    ok = 1'b0;
    bus.ARID_S = id; bus.ARADDR_S = addr; bus.ARLEN_S = len;
    bus.ARSIZE_S = size; bus.ARBURST_S = burst; bus.ARVALID_S = 1'b1;
    for (int c = 0; c < 20 && !ok; c++) begin
      if (bus.ARREADY_S) ok = 1'b1;
      @(negedge ACLK);
    end
    bus.ARVALID_S = 1'b0;
  endtask

  // Collects n beats; pat=1 toggles RREADY 1,0,0,1,...
  task automatic get_beats(input int n, input bit pat);
    logic held;
    logic [42:0] hold;
    got = 0; first_c = -1; last_c = -1; cs_n = 0; unstable = 0;
    held = 1'b0; hold = '0;
    for (int c = 0; c < 200 && got < n; c++) begin
      bus.RREADY_S = pat ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
      if (CS) cs_n++;
      if (held && (!bus.RVALID_S ||
          hold != {bus.RID_S, bus.RDATA_S, bus.RRESP_S, bus.RLAST_S}))
        unstable++;
      if (bus.RVALID_S && bus.RREADY_S) begin
        bd[got] = bus.RDATA_S; br[got] = bus.RRESP_S;
        bl[got] = bus.RLAST_S; bid[got] = bus.RID_S;
        if (first_c < 0) first_c = c;
        last_c = c;
        got++;
        held = 1'b0;
      end else if (bus.RVALID_S) begin
        held = 1'b1;
        hold = {bus.RID_S, bus.RDATA_S, bus.RRESP_S, bus.RLAST_S};
      end else begin
        held = 1'b0;
      end
      @(negedge ACLK);
    end
    bus.RREADY_S = 1'b1;
  endtask

  task automatic test_reset();
    ARESET = 1'b1;
    repeat (3) @(negedge ACLK);
    total++; if (bus.ARREADY_S !== 1'b0) begin bad++; $display("FAIL rst_arready got=%b exp=0", bus.ARREADY_S); end
    total++; if (bus.RVALID_S !== 1'b0) begin bad++; $display("FAIL rst_rvalid got=%b exp=0", bus.RVALID_S); end
    total++; if (bus.RLAST_S !== 1'b0) begin bad++; $display("FAIL rst_rlast got=%b exp=0", bus.RLAST_S); end
    total++; if (bus.RID_S !== 8'h00) begin bad++; $display("FAIL rst_rid got=%h exp=00", bus.RID_S); end
    total++; if (bus.RDATA_S !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", bus.RDATA_S); end
    total++; if (bus.RRESP_S !== 2'b00) begin bad++; $display("FAIL rst_rresp got=%b exp=00", bus.RRESP_S); end
    total++; if ({CS, OE} !== 2'b00) begin bad++; $display("FAIL rst_csoe got=%b exp=00", {CS, OE}); end
    total++; if (A !== 12'h0) begin bad++; $display("FAIL rst_a got=%h exp=0", A); end
    ARESET = 1'b0;
    repeat (2) @(negedge ACLK);
    total++; if (bus.ARREADY_S !== 1'b1) begin bad++; $display("FAIL idle_arready got=%b exp=1", bus.ARREADY_S); end
  endtask

  task automatic test_single();
    bit ok;
    send_ar(8'h5A, 32'h10, 4'd0, 3'd2, 2'b01, ok);
    total++; if (!ok) begin bad++; $display("FAIL single_ar got=timeout exp=handshake"); end
    get_beats(1, 1'b0);
    total++; if (got !== 1) begin bad++; $display("FAIL single_cnt got=%0d exp=1", got); end
    total++; if (first_c !== 1) begin bad++; $display("FAIL single_latency got=%0d exp=1", first_c); end
    total++; if (bd[0] !== rom_word(4)) begin bad++; $display("FAIL single_data got=%h exp=%h", bd[0], rom_word(4)); end
    total++; if (br[0] !== 2'b00) begin bad++; $display("FAIL single_resp got=%b exp=00", br[0]); end
    total++; if (bl[0] !== 1'b1) begin bad++; $display("FAIL single_last got=%b exp=1", bl[0]); end
    total++; if (bid[0] !== 8'h5A) begin bad++; $display("FAIL single_id got=%h exp=5a", bid[0]); end
    total++; if (cs_n !== 1) begin bad++; $display("FAIL single_cs got=%0d exp=1", cs_n); end
    total++; if (bus.ARREADY_S !== 1'b1) begin bad++; $display("FAIL single_arready_after got=%b exp=1", bus.ARREADY_S); end
  endtask

  task automatic test_incr16();
    bit ok;
    send_ar(8'h11, 32'h0, 4'd15, 3'd2, 2'b01, ok);
    total++; if (!ok) begin bad++; $display("FAIL incr_ar got=timeout exp=handshake"); end
    get_beats(16, 1'b0);
    total++; if (got !== 16) begin bad++; $display("FAIL incr_cnt got=%0d exp=16", got); end
    total++; if (last_c - first_c !== 15) begin bad++; $display("FAIL incr_gaps got=%0d exp=15", last_c - first_c); end
    for (int i = 0; i < 16; i++) begin
      total++; if (bd[i] !== rom_word(i)) begin bad++; $display("FAIL incr_data[%0d] got=%h exp=%h", i, bd[i], rom_word(i)); end
      total++; if (bl[i] !== (i == 15)) begin bad++; $display("FAIL incr_last[%0d] got=%b exp=%b", i, bl[i], i == 15); end
    end
  endtask

  task automatic test_wrap();
    bit ok;
    int exp_w [4] = '{14, 15, 12, 13};
    send_ar(8'h22, 32'h38, 4'd3, 3'd2, 2'b10, ok);
    total++; if (!ok) begin bad++; $display("FAIL wrap_ar got=timeout exp=handshake"); end
    get_beats(4, 1'b0);
    total++; if (got !== 4) begin bad++; $display("FAIL wrap_cnt got=%0d exp=4", got); end
    for (int i = 0; i < 4; i++) begin
      total++; if (bd[i] !== rom_word(exp_w[i])) begin bad++; $display("FAIL wrap_data[%0d] got=%h exp=%h", i, bd[i], rom_word(exp_w[i])); end
    end
    total++; if (bl[3] !== 1'b1) begin bad++; $display("FAIL wrap_last got=%b exp=1", bl[3]); end
  endtask

  task automatic test_wrap_bad();
    bit ok;
    send_ar(8'h23, 32'h38, 4'd2, 3'd2, 2'b10, ok);
    total++; if (!ok) begin bad++; $display("FAIL wrapbad_ar got=timeout exp=handshake"); end
    get_beats(3, 1'b0);
    total++; if (got !== 3) begin bad++; $display("FAIL wrapbad_cnt got=%0d exp=3", got); end
    for (int i = 0; i < 3; i++) begin
      total++; if (br[i] !== 2'b10) begin bad++; $display("FAIL wrapbad_resp[%0d] got=%b exp=10", i, br[i]); end
      total++; if (bd[i] !== 32'h0) begin bad++; $display("FAIL wrapbad_data[%0d] got=%h exp=0", i, bd[i]); end
    end
    total++; if (bl[2] !== 1'b1) begin bad++; $display("FAIL wrapbad_last got=%b exp=1", bl[2]); end
    total++; if (cs_n !== 0) begin bad++; $display("FAIL wrapbad_cs got=%0d exp=0", cs_n); end
  endtask

  task automatic test_backpressure();
    bit ok;
    send_ar(8'h33, 32'h20, 4'd7, 3'd2, 2'b01, ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_ar got=timeout exp=handshake"); end
    get_beats(8, 1'b1);
    total++; if (got !== 8) begin bad++; $display("FAIL bp_cnt got=%0d exp=8", got); end
    total++; if (unstable !== 0) begin bad++; $display("FAIL bp_stable got=%0d exp=0", unstable); end
    total++; if (cs_n !== 8) begin bad++; $display("FAIL bp_cs got=%0d exp=8", cs_n); end
    for (int i = 0; i < 8; i++) begin
      total++; if (bd[i] !== rom_word(8 + i)) begin bad++; $display("FAIL bp_data[%0d] got=%h exp=%h", i, bd[i], rom_word(8 + i)); end
      total++; if (bl[i] !== (i == 7)) begin bad++; $display("FAIL bp_last[%0d] got=%b exp=%b", i, bl[i], i == 7); end
    end
  endtask

  task automatic test_errors();
    bit ok;
    send_ar(8'h44, 32'h4000, 4'd1, 3'd2, 2'b01, ok);
    total++; if (!ok) begin bad++; $display("FAIL dec_ar got=timeout exp=handshake"); end
    get_beats(2, 1'b0);
    total++; if (got !== 2) begin bad++; $display("FAIL dec_cnt got=%0d exp=2", got); end
    for (int i = 0; i < 2; i++) begin
      total++; if (br[i] !== 2'b11) begin bad++; $display("FAIL dec_resp[%0d] got=%b exp=11", i, br[i]); end
      total++; if (bd[i] !== 32'h0) begin bad++; $display("FAIL dec_data[%0d] got=%h exp=0", i, bd[i]); end
    end
    total++; if (cs_n !== 0) begin bad++; $display("FAIL dec_cs got=%0d exp=0", cs_n); end
    send_ar(8'h45, 32'h0, 4'd0, 3'd3, 2'b01, ok);
    total++; if (!ok) begin bad++; $display("FAIL size_ar got=timeout exp=handshake"); end
    get_beats(1, 1'b0);
    total++; if (br[0] !== 2'b10) begin bad++; $display("FAIL size_resp got=%b exp=10", br[0]); end
    total++; if (bl[0] !== 1'b1) begin bad++; $display("FAIL size_last got=%b exp=1", bl[0]); end
    total++; if (cs_n !== 0) begin bad++; $display("FAIL size_cs got=%0d exp=0", cs_n); end
  endtask

  task automatic test_mid_reset();
    bit ok, hit;
    int hs;
    send_ar(8'h55, 32'h0, 4'd7, 3'd2, 2'b01, ok);
    total++; if (!ok) begin bad++; $display("FAIL mrst_ar got=timeout exp=handshake"); end
    hs = 0; hit = 1'b0;
    for (int c = 0; c < 50 && !hit; c++) begin
      if (bus.RVALID_S && hs == 3) begin
        hit = 1'b1;
        ARESET = 1'b1;
        bus.RREADY_S = 1'b0;
      end else if (bus.RVALID_S && bus.RREADY_S) begin
        hs++;
      end
      @(negedge ACLK);
    end
    total++; if (!hit) begin bad++; $display("FAIL mrst_beat3 got=timeout exp=beat3"); end
    total++; if (bus.RVALID_S !== 1'b0) begin bad++; $display("FAIL mrst_rvalid got=%b exp=0", bus.RVALID_S); end
    total++; if (bus.ARREADY_S !== 1'b0) begin bad++; $display("FAIL mrst_arready got=%b exp=0", bus.ARREADY_S); end
    ARESET = 1'b0;
    bus.RREADY_S = 1'b1;
    @(negedge ACLK);
    send_ar(8'h66, 32'h40, 4'd1, 3'd2, 2'b01, ok);
    total++; if (!ok) begin bad++; $display("FAIL mrst_ar2 got=timeout exp=handshake"); end
    get_beats(2, 1'b0);
    total++; if (got !== 2) begin bad++; $display("FAIL mrst_cnt got=%0d exp=2", got); end
    total++; if (bd[0] !== rom_word(16)) begin bad++; $display("FAIL mrst_d0 got=%h exp=%h", bd[0], rom_word(16)); end
    total++; if (bd[1] !== rom_word(17)) begin bad++; $display("FAIL mrst_d1 got=%h exp=%h", bd[1], rom_word(17)); end
    total++; if (bid[1] !== 8'h66) begin bad++; $display("FAIL mrst_id got=%h exp=66", bid[1]); end
    total++; if (bus.RVALID_S !== 1'b0) begin bad++; $display("FAIL mrst_stale got=%b exp=0", bus.RVALID_S); end
  endtask

`ifdef ROM_PARITY_EN
  task automatic test_parity();
    bit ok;
    flip_at = acc_n + 2;
    send_ar(8'h77, 32'h0, 4'd3, 3'd2, 2'b01, ok);
    total++; if (!ok) begin bad++; $display("FAIL par_ar got=timeout exp=handshake"); end
    get_beats(4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      total++; if (br[i] !== ((i == 2) ? 2'b10 : 2'b00)) begin bad++; $display("FAIL par_resp[%0d] got=%b exp=%b", i, br[i], (i == 2) ? 2'b10 : 2'b00); end
      total++; if (bd[i] !== rom_word(i)) begin bad++; $display("FAIL par_data[%0d] got=%h exp=%h", i, bd[i], rom_word(i)); end
    end
    flip_at = -1;
  endtask
`endif

  initial begin
    ARESET = 1'b1;
    bus.ARID_S = '0; bus.ARADDR_S = '0; bus.ARLEN_S = '0;
    bus.ARSIZE_S = 3'd2; bus.ARBURST_S = 2'b01;
    bus.ARVALID_S = 1'b0; bus.RREADY_S = 1'b1;
    @(negedge ACLK);
    test_reset();
    test_single();
    test_incr16();
    test_wrap();
    test_wrap_bad();
    test_backpressure();
    test_errors();
    test_mid_reset();
`ifdef ROM_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
